// File: rtl/positadd_arbiter_es3.sv
// Shares one positadd_4_raw_es3 pipeline among NREQ requesters: round-robin issue,
// a tag shift register that follows the adder latency, and credit-guarded result FIFOs.
module positadd_arbiter_es3 #(
   parameter int unsigned NREQ                           = 4,
   parameter int unsigned LAT                            = 4,
   parameter int unsigned DEPTH                          = 4,
   parameter int unsigned POSIT_SERIALIZED_WIDTH_ES3     = 16,
   parameter int unsigned POSIT_SERIALIZED_WIDTH_SUM_ES3 = 17
) (
   input  logic                                           clk,
   input  logic                                           reset,
   input  logic [NREQ-1:0]                                req_valid,
   output logic [NREQ-1:0]                                req_ready,
   input  logic [NREQ*POSIT_SERIALIZED_WIDTH_ES3-1:0]     req_in1,
   input  logic [NREQ*POSIT_SERIALIZED_WIDTH_ES3-1:0]     req_in2,
   output logic [NREQ-1:0]                                res_valid,
   input  logic [NREQ-1:0]                                res_ready,
   output logic [NREQ*POSIT_SERIALIZED_WIDTH_SUM_ES3-1:0] res_data,
   output logic [POSIT_SERIALIZED_WIDTH_ES3-1:0]          add_in1,
   output logic [POSIT_SERIALIZED_WIDTH_ES3-1:0]          add_in2,
   output logic                                           add_start,
   input  logic [POSIT_SERIALIZED_WIDTH_SUM_ES3-1:0]      add_result,
   input  logic                                           add_done,
   output logic                                           err
);

   localparam int unsigned PW = POSIT_SERIALIZED_WIDTH_ES3;
   localparam int unsigned SW = POSIT_SERIALIZED_WIDTH_SUM_ES3;
   localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned BW = $clog2(LAT + 1);

   logic [IW-1:0]   ptr_q;
   logic [IW-1:0]   grant;
   logic            found;
   logic            accept;
   logic [NREQ-1:0] elig;
   logic [NREQ-1:0] push;
   logic [NREQ-1:0] pop;
   logic [CW-1:0]   credit_q [NREQ];
   logic [CW-1:0]   cnt_q    [NREQ];
   logic [AW-1:0]   rd_q     [NREQ];
   logic [AW-1:0]   wr_q     [NREQ];
   logic [SW-1:0]   mem_q    [NREQ][DEPTH];
   logic [IW:0]     tag_q    [LAT];
   logic [BW-1:0]   blank_q;
   logic            err_q;
   logic            tail_v;
   logic [IW-1:0]   tail_id;
   logic            blanked;
   logic            do_write;
   logic            mismatch;

   function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      int unsigned idx;
      idx   = 0;
      found = 1'b0;
      grant = '0;
      for (int i = 0; i < NREQ; i++) begin
         elig[i] = req_valid[i] && (credit_q[i] < CW'(DEPTH));
      end
      // First eligible index at or after the pointer, wrapping around.
      for (int k = 0; k < NREQ; k++) begin
         idx = {{(32 - IW){1'b0}}, ptr_q} + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!found && elig[IW'(idx)]) begin
            found = 1'b1;
            grant = IW'(idx);
         end
      end
   end

   assign accept    = found && !reset;
   assign req_ready = accept ? (NREQ'(1) << grant) : '0;
   assign add_start = accept;
   assign add_in1   = accept ? req_in1[grant*PW +: PW] : '0;
   assign add_in2   = accept ? req_in2[grant*PW +: PW] : '0;

   assign tail_v   = tag_q[LAT-1][IW];
   assign tail_id  = tag_q[LAT-1][IW-1:0];
   // The adder is not reset; its output is meaningless until the window expires.
   assign blanked  = (blank_q != '0) || reset;
   assign do_write = add_done && tail_v && !blanked;
   assign mismatch = (add_done != tail_v) && !blanked;
   assign err      = err_q;

   always_comb begin
      res_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         push[i]      = do_write && (tail_id == IW'(i));
         res_valid[i] = (cnt_q[i] != '0) && !reset;
         pop[i]       = res_valid[i] && res_ready[i];
         res_data[i*SW +: SW] = reset ? '0 : mem_q[i][rd_q[i]];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q   <= '0;
         err_q   <= 1'b0;
         blank_q <= BW'(LAT);
         for (int s = 0; s < LAT; s++) tag_q[s] <= '0;
         for (int i = 0; i < NREQ; i++) begin
            credit_q[i] <= '0;
            cnt_q[i]    <= '0;
            rd_q[i]     <= '0;
            wr_q[i]     <= '0;
         end
      end else begin
         if (accept) ptr_q <= (grant == IW'(NREQ - 1)) ? '0 : grant + 1'b1;
         tag_q[0] <= {accept, grant};
         for (int s = 1; s < LAT; s++) tag_q[s] <= tag_q[s-1];
         if (blank_q != '0) blank_q <= blank_q - 1'b1;
         if (mismatch) err_q <= 1'b1;
         for (int i = 0; i < NREQ; i++) begin
            if (accept && (grant == IW'(i)) && !pop[i]) begin
               credit_q[i] <= credit_q[i] + 1'b1;
            end else if (!(accept && (grant == IW'(i))) && pop[i]) begin
               credit_q[i] <= credit_q[i] - 1'b1;
            end
            if (push[i]) wr_q[i] <= wrap_inc(wr_q[i]);
            if (pop[i]) rd_q[i] <= wrap_inc(rd_q[i]);
            cnt_q[i] <= cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NREQ; i++) begin
         if (push[i]) mem_q[i][wr_q[i]] <= add_result;
      end
   end

endmodule

// File: tb/tb_positadd_arbiter_es3.sv
// Bench for positadd_arbiter_es3 with a behavioural LAT-cycle adder stand-in that sums the raw
// operands as unsigned fixed point (1.0 = 16'h0100, 2.0 = 17'h00200).
module tb_positadd_arbiter_es3;

   localparam int unsigned NREQ  = 4;
   localparam int unsigned LAT   = 4;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned PW    = 16;
   localparam int unsigned SW    = 17;

   logic               clk = 1'b0;
   logic               reset;
   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_ready;
   logic [NREQ*PW-1:0] req_in1;
   logic [NREQ*PW-1:0] req_in2;
   logic [NREQ-1:0]    res_valid;
   logic [NREQ-1:0]    res_ready;
   logic [NREQ*SW-1:0] res_data;
   logic [PW-1:0]      add_in1;
   logic [PW-1:0]      add_in2;
   logic               add_start;
   logic [SW-1:0]      add_result;
   logic               add_done;
   logic               err;
   logic               inj_done;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic [3:0] valid;
      logic [3:0] rr;
      logic [3:0] exp;
   } row_t;
   row_t tbl [64];
   int   n_rows = 0;

   typedef struct {
      int          id;
      logic [16:0] data;
   } sb_t;
   sb_t sb [$];

   logic [LAT-1:0] pv = '0;
   logic [SW-1:0]  pd [LAT];

   always #5 clk = ~clk;

   positadd_arbiter_es3 #(
      .NREQ(NREQ), .LAT(LAT), .DEPTH(DEPTH),
      .POSIT_SERIALIZED_WIDTH_ES3(PW), .POSIT_SERIALIZED_WIDTH_SUM_ES3(SW)
   ) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_in1(req_in1), .req_in2(req_in2), .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .add_in1(add_in1), .add_in2(add_in2), .add_start(add_start),
      .add_result(add_result), .add_done(add_done), .err(err)
   );

   // Adder stand-in: no reset, fixed LAT-cycle latency.
   always @(posedge clk) begin
      pv    <= {pv[LAT-2:0], add_start};
      pd[0] <= {1'b0, add_in1} + {1'b0, add_in2};
      for (int s = 1; s < LAT; s++) pd[s] <= pd[s-1];
   end
   assign add_done   = pv[LAT-1] | inj_done;
   assign add_result = pd[LAT-1];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard: push the expected sum on every accept, compare on every consume.
   always @(negedge clk) begin
      if (reset) begin
         sb.delete();
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               sb.push_back('{id: i, data: {1'b0, req_in1[i*PW +: PW]} + {1'b0, req_in2[i*PW +: PW]}});
            end
         end
         for (int i = 0; i < NREQ; i++) begin
            if (res_valid[i] && res_ready[i]) begin
               bit hit;
               hit = 1'b0;
               for (int j = 0; j < sb.size(); j++) begin
                  if (!hit && sb[j].id == i) begin
                     hit = 1'b1;
                     check($sformatf("sb_data%0d", i), 32'(res_data[i*SW +: SW]), 32'(sb[j].data));
                     sb.delete(j);
                  end
               end
               if (!hit) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL sb_unexpected%0d: got %0h, expected no result", i,
                           res_data[i*SW +: SW]);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   task automatic cyc();
      @(posedge clk);
      #1;
      req_in1 = {$urandom, $urandom};
      req_in2 = {$urandom, $urandom};
   endtask

   task automatic add_row(input logic [3:0] v, input logic [3:0] rr, input logic [3:0] e);
      tbl[n_rows] = '{valid: v, rr: rr, exp: e};
      n_rows++;
   endtask

   initial begin
      reset     = 1'b1;
      req_valid = '0;
      res_ready = '0;
      req_in1   = '0;
      req_in2   = '0;
      inj_done  = 1'b0;

      // Round robin, all four requesters
      for (int k = 0; k < 12; k++) add_row(4'hF, 4'hF, 4'(1 << (k % 4)));
      for (int k = 0; k < 6; k++) add_row(4'h0, 4'hF, 4'h0);
      // Requester 2 back-pressured: DEPTH accepts, then one per freed credit
      for (int k = 0; k < 4; k++) add_row(4'h4, 4'hB, 4'h4);
      for (int k = 0; k < 7; k++) add_row(4'h4, 4'hB, 4'h0);
      add_row(4'h4, 4'hF, 4'h0);
      add_row(4'h4, 4'hB, 4'h4);
      for (int k = 0; k < 2; k++) add_row(4'h4, 4'hB, 4'h0);
      for (int k = 0; k < 10; k++) add_row(4'h0, 4'hF, 4'h0);
      // Fairness between 1 and 3 starting from ptr=2
      add_row(4'h2, 4'hF, 4'h2);
      add_row(4'hA, 4'hF, 4'h8);
      add_row(4'hA, 4'hF, 4'h2);
      add_row(4'hA, 4'hF, 4'h8);
      add_row(4'hA, 4'hF, 4'h2);
      for (int k = 0; k < 8; k++) add_row(4'h0, 4'hF, 4'h0);

      repeat (2) cyc();
      cyc();
      req_valid = '1;
      res_ready = '1;
      #4;
      check("rst_ready", 32'(req_ready), 32'h0);
      check("rst_start", 32'(add_start), 32'h0);
      check("rst_in1", 32'(add_in1), 32'h0);
      check("rst_in2", 32'(add_in2), 32'h0);
      check("rst_res_valid", 32'(res_valid), 32'h0);
      check("rst_res_data", 32'(|res_data), 32'h0);
      check("rst_err", 32'(err), 32'h0);

      cyc();
      reset     = 1'b0;
      req_valid = '0;
      repeat (LAT + 1) cyc();

      // Single pair 1.0 + 1.0 on requester 0
      req_valid = 4'h1;
      req_in1[15:0] = 16'h0100;
      req_in2[15:0] = 16'h0100;
      #4;
      check("a_ready", 32'(req_ready), 32'h1);
      check("a_start", 32'(add_start), 32'h1);
      check("a_in1", 32'(add_in1), 32'h0100);
      check("a_in2", 32'(add_in2), 32'h0100);
      for (int c = 1; c <= LAT + 1; c++) begin
         cyc();
         req_valid = '0;
         #4;
         check($sformatf("a_res_valid_c%0d", c), 32'(res_valid[0]), 32'(c == LAT + 1));
         if (c == LAT + 1) check("a_res_data", 32'(res_data[SW-1:0]), 32'h00200);
      end
      cyc();
      #4;
      check("a_drained", 32'(res_valid), 32'h0);

      cyc();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      repeat (LAT) cyc();

      for (int r = 0; r < n_rows; r++) begin
         cyc();
         req_valid = tbl[r].valid;
         res_ready = tbl[r].rr;
         #4;
         check($sformatf("grant_r%0d", r), 32'(req_ready), 32'(tbl[r].exp));
         check($sformatf("start_r%0d", r), 32'(add_start), 32'(|tbl[r].exp));
      end
      cyc();
      req_valid = '0;
      #4;
      check("sb_empty", 32'(sb.size()), 32'h0);

      // Reset with buffered and in-flight results
      res_ready = '0;
      for (int k = 0; k < 6; k++) begin
         cyc();
         req_valid = '1;
      end
      cyc();
      reset = 1'b1;
      #4;
      check("mid_rst_ready", 32'(req_ready), 32'h0);
      check("mid_rst_start", 32'(add_start), 32'h0);
      check("mid_rst_in1", 32'(add_in1), 32'h0);
      check("mid_rst_res_valid", 32'(res_valid), 32'h0);
      check("mid_rst_res_data", 32'(|res_data), 32'h0);
      for (int c = 1; c <= LAT + 2; c++) begin
         cyc();
         reset     = 1'b0;
         req_valid = '0;
         res_ready = '1;
         #4;
         check($sformatf("post_rst_res_valid_c%0d", c), 32'(res_valid), 32'h0);
         check($sformatf("post_rst_err_c%0d", c), 32'(err), 32'h0);
      end

      // Spurious add_done with an empty tag pipeline
      cyc();
      inj_done = 1'b1;
      #4;
      check("spur_err_before", 32'(err), 32'h0);
      cyc();
      inj_done = 1'b0;
      #4;
      check("spur_err_set", 32'(err), 32'h1);
      check("spur_no_write", 32'(res_valid), 32'h0);
      for (int c = 0; c < 3; c++) begin
         cyc();
         #4;
         check($sformatf("spur_err_hold%0d", c), 32'(err), 32'h1);
      end
      cyc();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      #4;
      check("spur_err_cleared", 32'(err), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
